// File: rtl/i2s_pkg.sv
// Shared types and sizing for the I2S receive master.
// Frame layout, FSM state encoding and derived widths live here.
package i2s_pkg;

   localparam int DATA_WIDTH = 24;
   localparam int CHNL_WIDTH = 32;
   localparam int FIFO_DEPTH = 8;

   localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1;
   localparam int BCNT_WIDTH = $clog2(CHNL_WIDTH + 1);
   localparam int FRM_WIDTH  = 2 * DATA_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] left;
      logic [DATA_WIDTH-1:0] right;
   } i2s_frame_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } i2s_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through frame FIFO; head_o is a register holding the head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module i2s_rx_fifo
   import i2s_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [FRM_WIDTH-1:0] push_data_i,
   input  logic                 pop_i,
   output logic [FRM_WIDTH-1:0] head_o,
   output logic                 empty_o,
   output logic [LVL_WIDTH-1:0] lvl_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(FIFO_DEPTH);

   i2s_frame_t           mem_q [FIFO_DEPTH];
   i2s_frame_t           head_q, head_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LVL_WIDTH-1:0] cnt_q, cnt_d;
   logic                 full, do_pop, do_push;

   always_comb begin
      full     = (cnt_q == FULL_LVL);
      do_pop   = pop_i && (cnt_q != '0);
      do_push  = push_i && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      cnt_d    = cnt_q + LVL_WIDTH'(do_push) - LVL_WIDTH'(do_pop);
      head_d   = head_q;
      // The head register tracks the next entry; an emptied FIFO keeps the last frame shown.
      if (cnt_d != '0) begin
         if ((cnt_q - LVL_WIDTH'(do_pop)) == '0) begin
            head_d = push_data_i;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   assign head_o  = head_q;
   assign empty_o = (cnt_q == '0);
   assign lvl_o   = cnt_q;

endmodule

// File: rtl/i2s_rx_master.sv
// I2S receive master: generates sck/ws, deserialises sd into {left,right} frames and queues them.
// Define I2S_RX_OVF_EN to add the sticky ovf_o flag and the saturating ovf_cnt_o drop counter.
module i2s_rx_master
   import i2s_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [7:0]           div_i,
   output logic                 sck_o,
   output logic                 ws_o,
   input  logic                 sd_i,
   output logic [FRM_WIDTH-1:0] dat_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [LVL_WIDTH-1:0] lvl_o
`ifdef I2S_RX_OVF_EN
   ,
   output logic                 ovf_o,
   output logic [15:0]          ovf_cnt_o
`endif
);

   localparam logic [BCNT_WIDTH-1:0] LAST_BIT = BCNT_WIDTH'(CHNL_WIDTH - 1);
   localparam logic [BCNT_WIDTH-1:0] DATA_LIM = BCNT_WIDTH'(DATA_WIDTH);

   i2s_state_e            state_q, state_d;
   logic [7:0]            div_q, div_d;
   logic [7:0]            hcnt_q, hcnt_d;
   logic                  sck_q, sck_d;
   logic                  ws_q, ws_d;
   logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic                  fall;
   logic                  push;
   i2s_frame_t            push_frame;
   logic                  fifo_empty;
   logic                  pop;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      hcnt_d     = hcnt_q;
      sck_d      = sck_q;
      ws_d       = ws_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      left_d     = left_q;
      fall       = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            hcnt_d = '0;
            sck_d  = 1'b0;
            ws_d   = 1'b0;
            bcnt_d = '0;
            if (en_i) begin
               state_d = RUN;
               div_d   = div_i;
            end
         end
         RUN, STOP: begin
            if (state_q == RUN && !en_i) begin
               state_d = STOP;
            end
            if (hcnt_q == div_q) begin
               hcnt_d = '0;
               sck_d  = !sck_q;
               fall   = sck_q;
            end else begin
               hcnt_d = hcnt_q + 8'd1;
            end
            // sd_i is captured on the edge that drops sck; bits past DATA_WIDTH are ignored.
            if (fall) begin
               if (bcnt_q < DATA_LIM) begin
                  shift_d = {shift_q[DATA_WIDTH-2:0], sd_i};
               end
               if (bcnt_q == LAST_BIT) begin
                  bcnt_d = '0;
                  ws_d   = !ws_q;
                  if (ws_q) begin
                     push = 1'b1;
                     if (state_q == STOP) begin
                        state_d = IDLE;
                     end
                  end else begin
                     left_d = shift_d;
                  end
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      push_frame.left  = left_q;
      push_frame.right = shift_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         hcnt_q  <= '0;
         sck_q   <= 1'b0;
         ws_q    <= 1'b0;
         bcnt_q  <= '0;
         shift_q <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         sck_q   <= sck_d;
         ws_q    <= ws_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         left_q  <= left_d;
      end
   end

   assign pop = valid_o && ready_i;

   i2s_rx_fifo u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_frame),
      .pop_i       (pop),
      .head_o      (dat_o),
      .empty_o     (fifo_empty),
      .lvl_o       (lvl_o)
   );

   assign sck_o   = sck_q;
   assign ws_o    = ws_q;
   assign valid_o = !fifo_empty;

`ifdef I2S_RX_OVF_EN
   logic        drop;
   logic        ovf_q, ovf_d;
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   // A push is lost only when the FIFO is full and nothing leaves in the same cycle.
   always_comb begin
      drop      = push && (lvl_o == LVL_WIDTH'(FIFO_DEPTH)) && !pop;
      ovf_d     = ovf_q | drop;
      ovf_cnt_d = ovf_cnt_q;
      if (drop && ovf_cnt_q != 16'hFFFF) begin
         ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_o     = ovf_q;
   assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: a serial transmitter model plus frame-level expectations.
// Build with I2S_RX_OVF_EN defined to also check the overflow outputs.
module tb_i2s_rx_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic [7:0]  div_i = 8'd0;
   logic        sck_o, ws_o;
   logic        sd_i = 1'b0;
   logic [47:0] dat_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [3:0]  lvl_o;
`ifdef I2S_RX_OVF_EN
   logic        ovf_o;
   logic [15:0] ovf_cnt_o;
`endif

   int          n_checks = 0;
   int          n_fail = 0;

   logic [47:0] tx_frames[$];
   int          tx_rise = 0;
   logic [47:0] rx_q[$];
   time         rx_t[$];
   time         sck_last = 0, sck_per = 0;
   time         ws_last = 0, ws_per = 0;

   i2s_rx_master dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .div_i     (div_i),
      .sck_o     (sck_o),
      .ws_o      (ws_o),
      .sd_i      (sd_i),
      .dat_o     (dat_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .lvl_o     (lvl_o)
`ifdef I2S_RX_OVF_EN
      ,
      .ovf_o     (ovf_o),
      .ovf_cnt_o (ovf_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Transmitter: each sck rise emits the next bit of a 64-bit frame, MSB first, zero-filled slot tail.
   always @(posedge sck_o) begin : tx_model
      int          f, b, p;
      logic [23:0] w;
      logic [63:0] r;
      f = tx_rise / 64;
      b = tx_rise % 64;
      p = b % 32;
      while (tx_frames.size() <= f) begin
         r = {$urandom, $urandom};
         tx_frames.push_back(r[47:0]);
      end
      w = (b < 32) ? tx_frames[f][47:24] : tx_frames[f][23:0];
      sd_i = (p < 24) ? w[23 - p] : 1'b0;
      tx_rise++;
      sck_per = (($time - sck_last) / 10);
      sck_last = $time;
   end

   always @(posedge ws_o) begin
      ws_per = (($time - ws_last) / 10);
      ws_last = $time;
   end

   always @(negedge clk_i) begin
      if (!rst_i && valid_o && ready_i) begin
         rx_q.push_back(dat_o);
         rx_t.push_back($time / 10);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic start_run(input logic [7:0] div, input logic rdy, input logic keep_frames);
      @(posedge clk_i);
      #1;
      tx_rise = 0;
      if (!keep_frames) tx_frames.delete();
      rx_q.delete();
      rx_t.delete();
      div_i   = div;
      ready_i = rdy;
      en_i    = 1'b1;
   endtask

   task automatic wait_rise(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (tx_rise < n && k < budget) begin
         @(posedge clk_i);
         k++;
      end
      #1;
      n_checks++;
      if (tx_rise < n) begin
         n_fail++;
         $display("[TB] FAIL %s timeout: rises %0d, required %0d", name, tx_rise, n);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      wait_cycles(3);
      n_checks += 5;
      if (sck_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sck: got %b expected 0", sck_o); end
      if (ws_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ws: got %b expected 0", ws_o); end
      if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
      if (dat_o !== 48'h0) begin n_fail++; $display("[TB] FAIL reset_dat: got %h expected 0", dat_o); end
      if (lvl_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_lvl: got %0d expected 0", lvl_o); end
      rst_i = 1'b0;
      wait_cycles(2);
   endtask

   task automatic test_basic();
      tx_frames.delete();
      repeat (3) tx_frames.push_back(48'hA5A5A55A5A5A);
      start_run(8'd0, 1'b1, 1'b1);
      wait_rise(3 * 64 + 8, 2000, "basic_run");
      en_i = 1'b0;
      wait_cycles(300);
      n_checks += 3;
      if (rx_q.size() != tx_rise / 64 || tx_rise % 64 != 0) begin
         n_fail++;
         $display("[TB] FAIL basic_count: got %0d frames, required %0d (rises %0d)", rx_q.size(), tx_rise / 64, tx_rise);
      end
      if (sck_o !== 1'b0 || ws_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_park: got sck=%b ws=%b expected 0/0", sck_o, ws_o);
      end
      if (rx_q.size() < 3 || rx_t[1] - rx_t[0] != 128 || rx_t[2] - rx_t[1] != 128) begin
         n_fail++;
         $display("[TB] FAIL basic_beat: got %0d frames / spacing %0d, required 128 clk", rx_q.size(), (rx_q.size() > 1) ? rx_t[1] - rx_t[0] : 0);
      end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== 48'hA5A5A55A5A5A) begin
            n_fail++;
            $display("[TB] FAIL basic_data[%0d]: got %h expected a5a5a55a5a5a", i, rx_q[i]);
         end
      end
   endtask

   task automatic test_div();
      start_run(8'd3, 1'b1, 1'b0);
      wait_rise(3 * 64 + 8, 4000, "div_run");
      en_i = 1'b0;
      wait_cycles(700);
      n_checks += 3;
      if (sck_per != 8) begin n_fail++; $display("[TB] FAIL div_sck_period: got %0d expected 8", sck_per); end
      if (ws_per != 512) begin n_fail++; $display("[TB] FAIL div_ws_period: got %0d expected 512", ws_per); end
      if (rx_q.size() != tx_rise / 64 || tx_rise % 64 != 0 || rx_q.size() < 3) begin
         n_fail++;
         $display("[TB] FAIL div_count: got %0d frames, required %0d (rises %0d)", rx_q.size(), tx_rise / 64, tx_rise);
      end
      for (int i = 0; i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== tx_frames[i]) begin
            n_fail++;
            $display("[TB] FAIL div_data[%0d]: got %h expected %h", i, rx_q[i], tx_frames[i]);
         end
      end
   endtask

   task automatic test_overflow();
      start_run(8'd0, 1'b0, 1'b0);
      wait_rise(9 * 64 + 10, 3000, "ovf_run");
      en_i = 1'b0;
      wait_cycles(300);
      n_checks += 4;
      if (tx_rise != 640) begin n_fail++; $display("[TB] FAIL ovf_sent: got %0d rises expected 640", tx_rise); end
      if (lvl_o !== 4'd8) begin n_fail++; $display("[TB] FAIL ovf_lvl_full: got %0d expected 8", lvl_o); end
      if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_valid: got %b expected 1", valid_o); end
      if (dat_o !== tx_frames[0]) begin n_fail++; $display("[TB] FAIL ovf_head: got %h expected %h", dat_o, tx_frames[0]); end
`ifdef I2S_RX_OVF_EN
      n_checks += 2;
      if (ovf_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b expected 1", ovf_o); end
      if (ovf_cnt_o !== 16'd2) begin n_fail++; $display("[TB] FAIL ovf_cnt: got %0d expected 2", ovf_cnt_o); end
`endif
      ready_i = 1'b1;
      wait_cycles(20);
      n_checks += 4;
      if (rx_q.size() != 8) begin n_fail++; $display("[TB] FAIL ovf_drain_count: got %0d expected 8", rx_q.size()); end
      if (lvl_o !== 4'd0) begin n_fail++; $display("[TB] FAIL ovf_lvl_empty: got %0d expected 0", lvl_o); end
      if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_valid_empty: got %b expected 0", valid_o); end
      if (dat_o !== tx_frames[7]) begin n_fail++; $display("[TB] FAIL ovf_hold: got %h expected %h", dat_o, tx_frames[7]); end
      for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== tx_frames[i]) begin
            n_fail++;
            $display("[TB] FAIL ovf_data[%0d]: got %h expected %h", i, rx_q[i], tx_frames[i]);
         end
      end
   endtask

   task automatic test_stop();
      int high;
      start_run(8'd1, 1'b1, 1'b0);
      wait_rise(64 + 10, 2000, "stop_run");
      en_i = 1'b0;
      wait_cycles(400);
      high = 0;
      repeat (50) begin
         @(negedge clk_i);
         if (sck_o !== 1'b0 || ws_o !== 1'b0) high++;
      end
      #1;
      n_checks += 3;
      if (rx_q.size() != 2 || tx_rise != 128) begin
         n_fail++;
         $display("[TB] FAIL stop_count: got %0d frames / %0d rises expected 2 / 128", rx_q.size(), tx_rise);
      end
      if (high != 0) begin n_fail++; $display("[TB] FAIL stop_park: got %0d active samples expected 0", high); end
      if (rx_q.size() > 1 && rx_q[1] !== tx_frames[1]) begin
         n_fail++;
         $display("[TB] FAIL stop_data: got %h expected %h", rx_q[1], tx_frames[1]);
      end
   endtask

   task automatic test_reset_mid();
      start_run(8'd0, 1'b1, 1'b0);
      wait_rise(64 + 40, 2000, "rstmid_run");
      rst_i = 1'b1;
      en_i  = 1'b0;
      @(posedge clk_i);
      #1;
      n_checks += 4;
      if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b expected 0", valid_o); end
      if (lvl_o !== 4'd0) begin n_fail++; $display("[TB] FAIL rstmid_lvl: got %0d expected 0", lvl_o); end
      if (sck_o !== 1'b0 || ws_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_clk: got sck=%b ws=%b expected 0/0", sck_o, ws_o); end
      if (dat_o !== 48'h0) begin n_fail++; $display("[TB] FAIL rstmid_dat: got %h expected 0", dat_o); end
`ifdef I2S_RX_OVF_EN
      n_checks++;
      if (ovf_o !== 1'b0 || ovf_cnt_o !== 16'd0) begin n_fail++; $display("[TB] FAIL rstmid_ovf: got %b/%0d expected 0/0", ovf_o, ovf_cnt_o); end
`endif
      rst_i = 1'b0;
      wait_cycles(2);
      start_run(8'd0, 1'b1, 1'b0);
      wait_rise(64 + 8, 2000, "rstmid_rerun");
      en_i = 1'b0;
      wait_cycles(300);
      n_checks++;
      if (rx_q.size() != tx_rise / 64 || tx_rise % 64 != 0 || rx_q.size() < 2) begin
         n_fail++;
         $display("[TB] FAIL rstmid_count: got %0d frames, required %0d (rises %0d)", rx_q.size(), tx_rise / 64, tx_rise);
      end
      for (int i = 0; i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== tx_frames[i]) begin
            n_fail++;
            $display("[TB] FAIL rstmid_data[%0d]: got %h expected %h", i, rx_q[i], tx_frames[i]);
         end
      end
   endtask

   task automatic test_div_latch();
      start_run(8'd1, 1'b1, 1'b0);
      wait_cycles(40);
      div_i = 8'd5;
      wait_cycles(200);
      n_checks++;
      if (sck_per != 4) begin n_fail++; $display("[TB] FAIL latch_keep: got period %0d expected 4", sck_per); end
      en_i = 1'b0;
      wait_cycles(400);
      start_run(8'd5, 1'b1, 1'b0);
      wait_cycles(200);
      n_checks++;
      if (sck_per != 12) begin n_fail++; $display("[TB] FAIL latch_new: got period %0d expected 12", sck_per); end
      en_i = 1'b0;
      wait_cycles(1000);
      n_checks++;
      if (rx_q.size() != tx_rise / 64 || tx_rise % 64 != 0 || rx_q.size() < 1) begin
         n_fail++;
         $display("[TB] FAIL latch_count: got %0d frames, required %0d (rises %0d)", rx_q.size(), tx_rise / 64, tx_rise);
      end
      for (int i = 0; i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== tx_frames[i]) begin
            n_fail++;
            $display("[TB] FAIL latch_data[%0d]: got %h expected %h", i, rx_q[i], tx_frames[i]);
         end
      end
   endtask

   initial begin
      $display("[TB] starting i2s_rx_master bench");
      test_reset();
      test_basic();
      test_div();
      test_overflow();
      test_stop();
      test_reset_mid();
      test_div_latch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
